// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Round-robin arbiter sharing one APB master transfer port between
//            NUM_REQ bus requesters; one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_transfer,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       m_transfer,
    output logic                       m_write,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_wdata,
    input  logic                       m_ready,
    input  logic [DATA_W-1:0]          m_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int c_ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic                r_m_write;

    logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata [NUM_REQ];
    logic                w_found;
    logic [c_ID_W-1:0]   w_sel;
    logic [c_ID_W-1:0]   w_cand;
    logic [c_ID_W:0]     w_sum;
    logic                w_complete;
    logic [c_ID_W-1:0]   w_ptr_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First pending requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_ID_W+1)'(i);
            if (w_sum >= (c_ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_ID_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[c_ID_W-1:0];
            if (!w_found && req_transfer[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_ptr_next = (r_grant_id == c_ID_W'(NUM_REQ-1)) ? '0
                                                           : r_grant_id + c_ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A ready coinciding with reset belongs to an abandoned transfer and is dropped.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        m_transfer   = 1'b0;
        busy         = 1'b0;
        req_ready    = '0;
        req_rdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_transfer   = 1'b1;
                busy         = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (m_ready && !reset) begin
                    w_complete            = 1'b1;
                    req_ready[r_grant_id] = 1'b1;
                    req_rdata             = m_rdata;
                    w_state_next          = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Transfer attributes are captured at grant and cleared on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_write  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant_id <= w_sel;
                r_m_addr   <= w_addr[w_sel];
                r_m_wdata  <= w_wdata[w_sel];
                r_m_write  <= req_write[w_sel];
            end
            if (w_complete) begin
                r_rr_ptr  <= w_ptr_next;
                r_m_addr  <= '0;
                r_m_wdata <= '0;
                r_m_write <= 1'b0;
            end
        end
    end

    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_write  = r_m_write;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_req_arbiter
// Brief    : Self-checking bench for apb_req_arbiter against a transaction-level
//            model, with directed scenarios and randomized requester traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_transfer;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   req_rdata;
    logic            m_transfer;
    logic            m_write;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_ready;
    logic [DW-1:0]   m_rdata;
    logic [IW-1:0]   grant_id;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_transfer(req_transfer), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .m_transfer(m_transfer), .m_write(m_write),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, stage 0=no transfer,
    // 1=start pulse cycle, 2=awaiting master ready.
    int              md_stage;
    int              md_ptr;
    int              md_g;
    int              md_pick;
    logic [AW-1:0]   md_addr;
    logic [DW-1:0]   md_wdata;
    logic            md_write;
    int              wait_cnt [N];

    initial forever begin
        @(posedge clk);
        if (reset) begin
            md_stage = 0; md_ptr = 0; md_g = 0;
            md_addr = '0; md_wdata = '0; md_write = 1'b0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (md_stage == 0) begin
            md_pick = -1;
            for (int k = 0; k < N; k++) begin
                if (md_pick < 0 && req_transfer[(md_ptr + k) % N]) md_pick = (md_ptr + k) % N;
            end
            if (md_pick >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i != md_pick && req_transfer[i]) begin
                        wait_cnt[i]++;
                        if (chk_en) chk("fair_wait_bound", 64'(wait_cnt[i] < N), 64'(1));
                    end
                end
                wait_cnt[md_pick] = 0;
                md_g     = md_pick;
                md_addr  = req_addr[md_pick*AW +: AW];
                md_wdata = req_wdata[md_pick*DW +: DW];
                md_write = req_write[md_pick];
                md_stage = 1;
            end
        end else if (md_stage == 1) begin
            md_stage = 2;
        end else if (m_ready) begin
            md_ptr   = (md_g + 1) % N;
            md_stage = 0;
            md_addr  = '0; md_wdata = '0; md_write = 1'b0;
        end
    end

    logic [N-1:0]  ex_ready;
    logic [DW-1:0] ex_rdata;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            ex_ready = '0;
            ex_rdata = '0;
            if (md_stage == 2 && m_ready && !reset) begin
                ex_ready[md_g] = 1'b1;
                ex_rdata       = m_rdata;
            end
            chk("busy",       64'(busy),       64'(md_stage != 0));
            chk("m_transfer", 64'(m_transfer), 64'(md_stage == 1));
            chk("m_addr",     64'(m_addr),     64'(md_addr));
            chk("m_wdata",    64'(m_wdata),    64'(md_wdata));
            chk("m_write",    64'(m_write),    64'(md_write));
            chk("grant_id",   64'(grant_id),   64'(md_g));
            chk("req_ready",  64'(req_ready),  64'(ex_ready));
            chk("req_rdata",  64'(req_rdata),  64'(ex_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_write[i]          = w;
    endtask

    task automatic reset_dut();
        tick();
        reset = 1'b1; req_transfer = '0; m_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Returns at the falling edge of the start-pulse cycle.
    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (m_transfer === 1'b1) ok = 1'b1;
            else tick();
        end
        chk("issue_seen", 64'(ok), 64'(1));
    endtask

    task automatic serve(input int id, input logic [AW-1:0] a, input bit drop);
        bit            ok;
        logic [N-1:0]  e;
        logic [DW-1:0] rd;
        wait_issue(ok);
        if (ok) begin
            chk("serve_grant",  64'(grant_id), 64'(id));
            chk("serve_m_addr", 64'(m_addr),   64'(a));
            tick();
            rd = $urandom;
            m_ready = 1'b1; m_rdata = rd;
            @(negedge clk);
            e = '0; e[id] = 1'b1;
            chk("serve_req_ready", 64'(req_ready), 64'(e));
            chk("serve_rdata",     64'(req_rdata), 64'(rd));
            tick();
            m_ready = 1'b0;
            if (drop) req_transfer[id] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] rr;
    bit           ok6;

    initial begin
        reset = 1'b1; req_transfer = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;
        tick(); tick();
        reset = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_grant_id",  64'(grant_id),  64'(0));
        chk("rst_m_addr",    64'(m_addr),    64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));

        // Single read
        tick();
        set_req(0, 32'h1000_0004, 32'h0, 1'b0);
        req_transfer = 2'b01;
        @(negedge clk);
        chk("t1_no_early_transfer", 64'(m_transfer), 64'(0));
        tick();
        @(negedge clk);
        chk("t1_m_transfer", 64'(m_transfer), 64'(1));
        chk("t1_m_addr",     64'(m_addr),     64'h1000_0004);
        chk("t1_m_write",    64'(m_write),    64'(0));
        tick();
        tick();
        m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'(2'b01));
        chk("t1_req_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
        tick();
        m_ready = 1'b0; req_transfer = 2'b00;
        @(negedge clk);
        chk("t1_busy_after", 64'(busy), 64'(0));

        // Simultaneous requests from reset
        reset_dut();
        set_req(0, 32'hA000_0000, 32'h1111_0000, 1'b1);
        set_req(1, 32'hB000_0010, 32'h2222_0000, 1'b0);
        req_transfer = 2'b11;
        serve(0, 32'hA000_0000, 1'b1);
        serve(1, 32'hB000_0010, 1'b1);

        // Fairness with both requesters holding their request
        reset_dut();
        req_transfer = 2'b11;
        serve(0, 32'hA000_0000, 1'b0);
        serve(1, 32'hB000_0010, 1'b0);
        serve(0, 32'hA000_0000, 1'b0);
        serve(1, 32'hB000_0010, 1'b0);
        req_transfer = 2'b00;

        // Latched attributes ignore requester changes after grant
        tick();
        set_req(0, 32'h1000_0000, 32'h0, 1'b0);
        req_transfer = 2'b01;
        wait_issue(ok6);
        tick();
        set_req(0, 32'h2000_0000, 32'h0, 1'b1);
        tick();
        @(negedge clk);
        chk("t4_m_addr_held",  64'(m_addr),  64'h1000_0000);
        chk("t4_m_write_held", 64'(m_write), 64'(0));
        tick();
        m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("t4_req_ready", 64'(req_ready), 64'(2'b01));
        tick();
        m_ready = 1'b0; req_transfer = 2'b00;

        // Spurious ready in IDLE and in the start-pulse cycle
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        chk("t5_idle_ready", 64'(req_ready), 64'(0));
        chk("t5_idle_busy",  64'(busy),      64'(0));
        tick();
        m_ready = 1'b0;
        set_req(1, 32'h3000_0008, 32'h0, 1'b0);
        req_transfer = 2'b10;
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        chk("t5_issue_transfer", 64'(m_transfer), 64'(1));
        chk("t5_issue_ready",    64'(req_ready),  64'(0));
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("t5_wait_busy",  64'(busy),      64'(1));
        chk("t5_wait_ready", 64'(req_ready), 64'(0));
        tick();
        m_ready = 1'b1; m_rdata = 32'h5A5A_A5A5;
        @(negedge clk);
        chk("t5_req_ready", 64'(req_ready), 64'(2'b10));
        chk("t5_req_rdata", 64'(req_rdata), 64'h5A5A_A5A5);
        tick();
        m_ready = 1'b0; req_transfer = 2'b00;

        // Reset while waiting for the master
        tick();
        set_req(0, 32'h4000_0000, 32'hCAFE_0000, 1'b1);
        req_transfer = 2'b01;
        wait_issue(ok6);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; req_transfer = 2'b00;
        @(negedge clk);
        chk("t6_busy",      64'(busy),       64'(0));
        chk("t6_grant_id",  64'(grant_id),   64'(0));
        chk("t6_m_addr",    64'(m_addr),     64'(0));
        chk("t6_m_wdata",   64'(m_wdata),    64'(0));
        chk("t6_m_write",   64'(m_write),    64'(0));
        chk("t6_req_ready", 64'(req_ready),  64'(0));
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        chk("t6_stale_ready", 64'(req_ready), 64'(0));
        tick();
        m_ready = 1'b0;
        set_req(1, 32'h5000_0004, 32'h0, 1'b0);
        req_transfer = 2'b10;
        serve(1, 32'h5000_0004, 1'b1);

        // Randomized traffic; requesters hold until served, then renew or drop
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rr = req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (rr[i]) begin
                    req_transfer[i] = 1'($urandom_range(0, 1));
                    set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
                end else if (!req_transfer[i] && $urandom_range(0, 3) == 0) begin
                    req_transfer[i] = 1'b1;
                    set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
                end else if (req_transfer[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
                end
            end
            m_ready = ($urandom_range(0, 2) == 0);
            m_rdata = $urandom;
        end
        tick();
        req_transfer = '0; m_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
